m16_pattern_filler: RTL and testbench

Parametrised telemetry-word filler for the M16 imitator. On each buffer word request it returns a registered 12-bit-style data word chosen by a run-time programmable table of NUM_CH pattern channels. Each channel matches read-pointer slots through a value/mask pair and produces a constant, up, down, triangle, or group-gated counter pattern that steps once per frame. It sits between the frame buffer read logic and the serialiser, alongside or in place of the fixed-slot filler.

---
 rtl/m16_filler_pkg.sv | 52 +++++
 rtl/m16_pattern_chan.sv | 112 +++++++++++
 rtl/m16_pattern_filler.sv | 113 +++++++++++
 tb/tb_m16_pattern_filler.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/m16_filler_pkg.sv
// Shared definitions for the M16 pattern filler: channel modes, default
// idle word and a channel configuration record at the default widths.
package m16_filler_pkg;

    // Channel pattern modes; encoding matches the cfg_mode port values.
    typedef enum logic [2:0] {
        MODE_OFF    = 3'd0,
        MODE_CONST  = 3'd1,
        MODE_UP     = 3'd2,
        MODE_DOWN   = 3'd3,
        MODE_UPDOWN = 3'd4,
        MODE_GRP_UP = 3'd5
    } mode_e;

    localparam int DEF_WORD_W = 12;
    localparam int DEF_PTR_W  = 11;
    localparam int DEF_CNT_W  = 10;
    localparam int DEF_GRP_W  = 5;

    // Word returned when no channel supplies data.
    localparam logic [DEF_WORD_W-1:0] DEF_IDLE_WORD = 12'h002;

    // One channel's programmed configuration at the default widths.
    typedef struct packed {
        mode_e                mode;
        logic [DEF_PTR_W-1:0] slot;
        logic [DEF_PTR_W-1:0] mask;
        logic [DEF_CNT_W-1:0] init;
        logic [DEF_GRP_W-1:0] grp;
    } chan_cfg_t;

    // Raw mode field to enum; unused encodings disable the channel.
    function automatic mode_e decode_mode(input logic [2:0] raw);
        mode_e m;
        case (raw)
            3'd1:    m = MODE_CONST;
            3'd2:    m = MODE_UP;
            3'd3:    m = MODE_DOWN;
            3'd4:    m = MODE_UPDOWN;
            3'd5:    m = MODE_GRP_UP;
            default: m = MODE_OFF;
        endcase
        return m;
    endfunction

    // True for modes whose value comes from the stepping counter.
    function automatic logic is_counter(input mode_e m);
        return (m == MODE_UP) || (m == MODE_DOWN) ||
               (m == MODE_UPDOWN) || (m == MODE_GRP_UP);
    endfunction

endpackage

// File: rtl/m16_pattern_chan.sv
// One pattern channel: configuration registers, slot matcher, counter with
// direction bit, and the once-per-frame armed flag.
module m16_pattern_chan
    import m16_filler_pkg::*;
#(
    parameter int PTR_W = 11,
    parameter int CNT_W = 10,
    parameter int GRP_W = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_get,
    input  logic [PTR_W-1:0] i_ptr,
    input  logic [GRP_W-1:0] i_grp,
    input  logic             i_cfg_we,
    input  logic [2:0]       i_cfg_mode,
    input  logic [PTR_W-1:0] i_cfg_slot,
    input  logic [PTR_W-1:0] i_cfg_mask,
    input  logic [CNT_W-1:0] i_cfg_init,
    input  logic [GRP_W-1:0] i_cfg_grp,
    input  logic             i_step,
    output logic             o_match,
    output logic [CNT_W-1:0] o_value,
    output logic             o_group_ok,
    output logic             o_armed
);

    mode_e            r_mode;
    logic [PTR_W-1:0] r_slot;
    logic [PTR_W-1:0] r_mask;
    logic [CNT_W-1:0] r_init;
    logic [GRP_W-1:0] r_grp;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dir_down;
    logic             r_armed;

    logic             w_match;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_dir_next;

    assign w_match    = (r_mode != MODE_OFF) &&
                        ((i_ptr & r_mask) == (r_slot & r_mask));
    assign o_match    = w_match;
    assign o_value    = (r_mode == MODE_CONST) ? r_init : r_cnt;
    assign o_group_ok = (r_mode != MODE_GRP_UP) || (i_grp == r_grp);
    assign o_armed    = r_armed;

    // Next counter value and direction for one step in the current mode.
    always_comb begin
        w_cnt_next = r_cnt;
        w_dir_next = r_dir_down;
        case (r_mode)
            MODE_UP, MODE_GRP_UP: w_cnt_next = r_cnt + CNT_W'(1);
            MODE_DOWN:            w_cnt_next = r_cnt - CNT_W'(1);
            MODE_UPDOWN: begin
                // Turn at an extreme: flip direction and move away from it in
                // the same step, so each extreme is emitted exactly once.
                if (!r_dir_down) begin
                    if (r_cnt == '1) begin
                        w_dir_next = 1'b1;
                        w_cnt_next = r_cnt - CNT_W'(1);
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end else begin
                    if (r_cnt == '0) begin
                        w_dir_next = 1'b0;
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end else begin
                        w_cnt_next = r_cnt - CNT_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    // Config load, counter stepping and armed flag maintenance.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_mode     <= MODE_OFF;
            r_slot     <= '0;
            r_mask     <= '0;
            r_init     <= '0;
            r_grp      <= '0;
            r_cnt      <= '0;
            r_dir_down <= 1'b0;
            r_armed    <= 1'b1;
        end else if (i_cfg_we) begin
            // A config write takes priority over any step on this channel.
            r_mode     <= decode_mode(i_cfg_mode);
            r_slot     <= i_cfg_slot;
            r_mask     <= i_cfg_mask;
            r_init     <= i_cfg_init;
            r_grp      <= i_cfg_grp;
            r_cnt      <= i_cfg_init;
            r_dir_down <= 1'b0;
            r_armed    <= 1'b1;
        end else if (i_get) begin
            if (i_step) begin
                if (is_counter(r_mode)) begin
                    r_cnt      <= w_cnt_next;
                    r_dir_down <= w_dir_next;
                end
                r_armed <= 1'b0;
            end else if (!w_match) begin
                r_armed <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/m16_pattern_filler.sv
// Telemetry word filler: NUM_CH pattern channels, lowest-index priority
// select, output word formatting and registered data/valid outputs.
module m16_pattern_filler
    import m16_filler_pkg::*;
#(
    parameter int                WORD_W    = 12,
    parameter int                PTR_W     = 11,
    parameter int                CNT_W     = 10,
    parameter int                GRP_W     = 5,
    parameter int                NUM_CH    = 8,
    parameter logic [WORD_W-1:0] IDLE_WORD = WORD_W'(DEF_IDLE_WORD),
    localparam int               CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bufGetWord,
    input  logic [PTR_W-1:0]  bufRdPointer,
    input  logic [GRP_W-1:0]  numGrp,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [2:0]        cfg_mode,
    input  logic [PTR_W-1:0]  cfg_slot,
    input  logic [PTR_W-1:0]  cfg_mask,
    input  logic [CNT_W-1:0]  cfg_init,
    input  logic [GRP_W-1:0]  cfg_grp,
    output logic [WORD_W-1:0] dataWord,
    output logic              dataValid
);

    localparam int PAD_W = WORD_W - 1 - CNT_W;

    logic [NUM_CH-1:0] w_ch_we;
    logic [NUM_CH-1:0] w_match;
    logic [NUM_CH-1:0] w_group_ok;
    logic [NUM_CH-1:0] w_armed;
    logic [NUM_CH-1:0] w_step;
    logic [CNT_W-1:0]  w_value [NUM_CH];

    logic              w_hit;
    logic              w_win_grp_ok;
    logic [CNT_W-1:0]  w_win_value;
    logic [NUM_CH-1:0] w_win_onehot;
    logic [WORD_W-1:0] w_fmt_word;
    logic [WORD_W-1:0] w_out_word;

    logic [WORD_W-1:0] r_data_word;
    logic              r_data_valid;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_ch_we[g] = cfg_we && (cfg_ch == CH_W'(g));

        m16_pattern_chan #(
            .PTR_W (PTR_W),
            .CNT_W (CNT_W),
            .GRP_W (GRP_W)
        ) u_chan (
            .i_clk      (clk),
            .i_rst_n    (reset),
            .i_get      (bufGetWord),
            .i_ptr      (bufRdPointer),
            .i_grp      (numGrp),
            .i_cfg_we   (w_ch_we[g]),
            .i_cfg_mode (cfg_mode),
            .i_cfg_slot (cfg_slot),
            .i_cfg_mask (cfg_mask),
            .i_cfg_init (cfg_init),
            .i_cfg_grp  (cfg_grp),
            .i_step     (w_step[g]),
            .o_match    (w_match[g]),
            .o_value    (w_value[g]),
            .o_group_ok (w_group_ok[g]),
            .o_armed    (w_armed[g])
        );
    end

    // Lowest-index matching channel wins; capture its value and group status.
    always_comb begin
        w_hit        = 1'b0;
        w_win_grp_ok = 1'b0;
        w_win_value  = '0;
        w_win_onehot = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (w_match[i] && !w_hit) begin
                w_hit           = 1'b1;
                w_win_grp_ok    = w_group_ok[i];
                w_win_value     = w_value[i];
                w_win_onehot[i] = 1'b1;
            end
        end
    end

    // Only an armed winner whose group requirement is met advances.
    assign w_step     = {NUM_CH{bufGetWord && w_win_grp_ok}} & w_win_onehot & w_armed;
    assign w_fmt_word = WORD_W'(w_win_value) << PAD_W;
    assign w_out_word = (w_hit && w_win_grp_ok) ? w_fmt_word : IDLE_WORD;

    // Register the selected word on each request; hold it otherwise.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_data_word  <= '0;
            r_data_valid <= 1'b0;
        end else begin
            r_data_valid <= bufGetWord;
            if (bufGetWord) begin
                r_data_word <= w_out_word;
            end
        end
    end

    assign dataWord  = r_data_word;
    assign dataValid = r_data_valid;

endmodule

// File: tb/tb_m16_pattern_filler.sv
// Self-checking bench for m16_pattern_filler: directed scenarios plus a
// randomized run against a behavioural channel-table model.
module tb_m16_pattern_filler;

    localparam int          WORD_W = 12;
    localparam int          PTR_W  = 11;
    localparam int          CNT_W  = 10;
    localparam int          GRP_W  = 5;
    localparam int          NUM_CH = 8;
    localparam int unsigned CMAX   = 1023;
    localparam logic [11:0] IDLE   = 12'h002;

    logic              clk = 1'b0;
    logic              reset;
    logic              bufGetWord;
    logic [PTR_W-1:0]  bufRdPointer;
    logic [GRP_W-1:0]  numGrp;
    logic              cfg_we;
    logic [2:0]        cfg_ch;
    logic [2:0]        cfg_mode;
    logic [PTR_W-1:0]  cfg_slot;
    logic [PTR_W-1:0]  cfg_mask;
    logic [CNT_W-1:0]  cfg_init;
    logic [GRP_W-1:0]  cfg_grp;
    logic [WORD_W-1:0] dataWord;
    logic              dataValid;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    m16_pattern_filler #(
        .WORD_W    (WORD_W),
        .PTR_W     (PTR_W),
        .CNT_W     (CNT_W),
        .GRP_W     (GRP_W),
        .NUM_CH    (NUM_CH),
        .IDLE_WORD (IDLE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bufGetWord   (bufGetWord),
        .bufRdPointer (bufRdPointer),
        .numGrp       (numGrp),
        .cfg_we       (cfg_we),
        .cfg_ch       (cfg_ch),
        .cfg_mode     (cfg_mode),
        .cfg_slot     (cfg_slot),
        .cfg_mask     (cfg_mask),
        .cfg_init     (cfg_init),
        .cfg_grp      (cfg_grp),
        .dataWord     (dataWord),
        .dataValid    (dataValid)
    );

    // ---------------- behavioural model ----------------
    // Counter modes keep a plain integer; UPDOWN keeps a phase on a
    // triangle of period 2*CMAX and derives the value from it.
    int unsigned m_mode  [NUM_CH];
    logic [10:0] m_slot  [NUM_CH];
    logic [10:0] m_mask  [NUM_CH];
    logic [9:0]  m_init  [NUM_CH];
    logic [4:0]  m_grp   [NUM_CH];
    int unsigned m_cnt   [NUM_CH];
    bit          m_armed [NUM_CH];
    logic [11:0] last_word;

    function automatic void model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_mode[i] = 0; m_slot[i] = '0; m_mask[i] = '0; m_init[i] = '0;
            m_grp[i] = '0; m_cnt[i] = 0; m_armed[i] = 1'b1;
        end
        last_word = '0;
    endfunction

    function automatic void model_cfg(input int ch, input int unsigned mode, input logic [10:0] slot,
                                      input logic [10:0] mask, input logic [9:0] init, input logic [4:0] grp);
        m_mode[ch] = (mode > 5) ? 0 : mode;
        m_slot[ch] = slot; m_mask[ch] = mask; m_init[ch] = init; m_grp[ch] = grp;
        m_cnt[ch] = 32'(init); m_armed[ch] = 1'b1;
    endfunction

    function automatic logic [11:0] model_req(input logic [10:0] ptr, input logic [4:0] grp);
        int          win;
        logic [31:0] v;
        logic [11:0] res;
        bit          hit [NUM_CH];
        win = -1; res = IDLE; v = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            hit[i] = (m_mode[i] != 0) && ((ptr & m_mask[i]) == (m_slot[i] & m_mask[i]));
            if (hit[i] && win < 0) win = i;
        end
        if (win >= 0 && !(m_mode[win] == 5 && grp != m_grp[win])) begin
            if (m_mode[win] == 1)      v = 32'(m_init[win]);
            else if (m_mode[win] == 4) v = (m_cnt[win] <= CMAX) ? m_cnt[win] : 2 * CMAX - m_cnt[win];
            else                       v = m_cnt[win];
            res = {1'b0, v[9:0], 1'b0};
            if (m_mode[win] >= 2 && m_armed[win]) begin
                case (m_mode[win])
                    3:       m_cnt[win] = (m_cnt[win] + CMAX) % (CMAX + 1);
                    4:       m_cnt[win] = (m_cnt[win] + 1) % (2 * CMAX);
                    default: m_cnt[win] = (m_cnt[win] + 1) % (CMAX + 1);
                endcase
                m_armed[win] = 1'b0;
            end
        end
        for (int i = 0; i < NUM_CH; i++) if (!hit[i]) m_armed[i] = 1'b1;
        return res;
    endfunction

    // ---------------- stimulus helpers ----------------
    // Called at a negedge; drives one cycle and returns at the next negedge
    // with the expected registered word.
    task automatic drive_cycle(input bit get, input logic [10:0] ptr, input logic [4:0] grp,
                               input bit we, input logic [2:0] ch, input logic [2:0] mode,
                               input logic [10:0] slot, input logic [10:0] mask,
                               input logic [9:0] init, input logic [4:0] cgrp,
                               output logic [11:0] exp_word);
        bufGetWord = get; bufRdPointer = ptr; numGrp = grp;
        cfg_we = we; cfg_ch = ch; cfg_mode = mode; cfg_slot = slot;
        cfg_mask = mask; cfg_init = init; cfg_grp = cgrp;
        if (get) last_word = model_req(ptr, grp);
        if (we) model_cfg(int'(ch), 32'(mode), slot, mask, init, cgrp);
        exp_word = last_word;
        @(negedge clk);
        bufGetWord = 1'b0; cfg_we = 1'b0;
    endtask

    task automatic req(input logic [10:0] ptr, input logic [4:0] grp, output logic [11:0] e);
        drive_cycle(1'b1, ptr, grp, 1'b0, 3'd0, 3'd0, 11'd0, 11'd0, 10'd0, 5'd0, e);
    endtask

    task automatic cfg(input logic [2:0] ch, input logic [2:0] mode, input logic [10:0] slot,
                       input logic [10:0] mask, input logic [9:0] init, input logic [4:0] grp);
        logic [11:0] d;
        drive_cycle(1'b0, 11'd0, 5'd0, 1'b1, ch, mode, slot, mask, init, grp, d);
    endtask

    task automatic idle(output logic [11:0] e);
        drive_cycle(1'b0, 11'd0, 5'd0, 1'b0, 3'd0, 3'd0, 11'd0, 11'd0, 10'd0, 5'd0, e);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [11:0] e;
        reset = 1'b0;
        idle(e); idle(e);
        model_reset();
        n_vec++;
        if (dataWord !== 12'h000 || dataValid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: dataWord=%h dataValid=%b, want 000/0", dataWord, dataValid);
        end
        reset = 1'b1;
        req(11'd5, 5'd0, e);
        n_vec++;
        if (dataWord !== 12'h002 || dataValid !== 1'b1) begin
            n_err++;
            $display("FAIL reset_first_req: dataWord=%h dataValid=%b, want 002/1", dataWord, dataValid);
        end
        idle(e);
        n_vec++;
        if (dataWord !== 12'h002 || dataValid !== 1'b0) begin
            n_err++;
            $display("FAIL valid_pulse_hold: dataWord=%h dataValid=%b, want 002/0", dataWord, dataValid);
        end
    endtask

    task automatic test_up();
        logic [10:0] ptrs [6];
        logic [11:0] want [6];
        logic [11:0] e;
        ptrs = '{11'd2, 11'd2, 11'd7, 11'd2, 11'd7, 11'd2};
        want = '{12'h000, 12'h002, 12'h002, 12'h002, 12'h002, 12'h004};
        cfg(3'd0, 3'd2, 11'd2, 11'h7FF, 10'd0, 5'd0);
        for (int i = 0; i < 6; i++) begin
            req(ptrs[i], 5'd0, e);
            n_vec++;
            if (dataWord !== want[i] || dataValid !== 1'b1) begin
                n_err++;
                $display("FAIL up_step[%0d]: dataWord=%h dataValid=%b, want %h/1", i, dataWord, dataValid, want[i]);
            end
        end
    endtask

    task automatic test_down();
        logic [10:0] ptrs [5];
        logic [11:0] want [5];
        logic [11:0] e;
        ptrs = '{11'd3, 11'd7, 11'd3, 11'd7, 11'd3};
        want = '{12'h000, 12'h002, 12'h7FE, 12'h002, 12'h7FC};
        cfg(3'd1, 3'd3, 11'd3, 11'h7FF, 10'd0, 5'd0);
        for (int i = 0; i < 5; i++) begin
            req(ptrs[i], 5'd0, e);
            n_vec++;
            if (dataWord !== want[i]) begin
                n_err++;
                $display("FAIL down_wrap[%0d]: dataWord=%h, want %h", i, dataWord, want[i]);
            end
        end
    endtask

    task automatic test_const_priority();
        logic [10:0] ptrs [4];
        logic [11:0] e;
        ptrs = '{11'd1, 11'd33, 11'd2017, 11'd1};
        cfg(3'd2, 3'd1, 11'd1, 11'h01F, 10'h1B8, 5'd0);
        for (int i = 0; i < 4; i++) begin
            req(ptrs[i], 5'd0, e);
            n_vec++;
            if (dataWord !== 12'h370) begin
                n_err++;
                $display("FAIL const_mask[%0d]: dataWord=%h, want 370", i, dataWord);
            end
        end
        cfg(3'd0, 3'd2, 11'd1, 11'h01F, 10'd5, 5'd0);
        req(11'd1, 5'd0, e);
        n_vec++;
        if (dataWord !== 12'h00A) begin
            n_err++;
            $display("FAIL priority_ch0: dataWord=%h, want 00A", dataWord);
        end
        req(11'd33, 5'd0, e);
        n_vec++;
        if (dataWord !== 12'h00C) begin
            n_err++;
            $display("FAIL priority_ch0_again: dataWord=%h, want 00C", dataWord);
        end
        req(11'd2, 5'd0, e);
        n_vec++;
        if (dataWord !== IDLE) begin
            n_err++;
            $display("FAIL no_match_idle: dataWord=%h, want 002", dataWord);
        end
    endtask

    task automatic test_grp_up();
        logic [10:0] ptrs [4];
        logic [4:0]  grps [4];
        logic [11:0] want [4];
        logic [11:0] e;
        ptrs = '{11'd594, 11'd594, 11'd7, 11'd594};
        grps = '{5'd0, 5'd1, 5'd1, 5'd1};
        want = '{12'h002, 12'h020, 12'h002, 12'h022};
        cfg(3'd3, 3'd5, 11'd594, 11'h7FF, 10'h010, 5'd1);
        for (int i = 0; i < 4; i++) begin
            req(ptrs[i], grps[i], e);
            n_vec++;
            if (dataWord !== want[i]) begin
                n_err++;
                $display("FAIL grp_up[%0d]: dataWord=%h, want %h", i, dataWord, want[i]);
            end
        end
    endtask

    task automatic test_updown_and_cfg_collision();
        logic [11:0] e;
        logic [11:0] lit;
        cfg(3'd4, 3'd4, 11'd100, 11'h7FF, 10'h3FE, 5'd0);
        for (int k = 0; k < 1030; k++) begin
            req(11'd100, 5'd0, e);
            n_vec++;
            if (dataWord !== e) begin
                n_err++;
                $display("FAIL updown_frame[%0d]: dataWord=%h, want %h", k, dataWord, e);
            end
            if (k == 0 || k == 1 || k == 2 || k == 1023 || k == 1024 || k == 1025) begin
                case (k)
                    0, 2:       lit = 12'h7FC;
                    1:          lit = 12'h7FE;
                    1024:       lit = 12'h000;
                    default:    lit = 12'h002;
                endcase
                n_vec++;
                if (dataWord !== lit) begin
                    n_err++;
                    $display("FAIL updown_extreme[%0d]: dataWord=%h, want %h", k, dataWord, lit);
                end
            end
            req(11'd7, 5'd0, e);
        end
        // Phase 6 now pending; write ch4 in the same cycle as its request.
        drive_cycle(1'b1, 11'd100, 5'd0, 1'b1, 3'd4, 3'd4, 11'd100, 11'h7FF, 10'h055, 5'd0, e);
        n_vec++;
        if (dataWord !== 12'h00C || dataValid !== 1'b1) begin
            n_err++;
            $display("FAIL cfg_collision_old: dataWord=%h dataValid=%b, want 00C/1", dataWord, dataValid);
        end
        req(11'd100, 5'd0, e);
        n_vec++;
        if (dataWord !== 12'h0AA) begin
            n_err++;
            $display("FAIL cfg_collision_reload: dataWord=%h, want 0AA", dataWord);
        end
        req(11'd100, 5'd0, e);
        n_vec++;
        if (dataWord !== 12'h0AC) begin
            n_err++;
            $display("FAIL back_to_back_one_step: dataWord=%h, want 0AC", dataWord);
        end
    endtask

    task automatic test_reset_mid();
        logic [11:0] e;
        reset = 1'b0;
        bufGetWord = 1'b1; bufRdPointer = 11'd1; numGrp = 5'd0;
        cfg_we = 1'b1; cfg_ch = 3'd5; cfg_mode = 3'd1; cfg_slot = 11'd1;
        cfg_mask = 11'h7FF; cfg_init = 10'h3FF; cfg_grp = 5'd0;
        @(negedge clk);
        bufGetWord = 1'b0; cfg_we = 1'b0; reset = 1'b1;
        model_reset();
        n_vec++;
        if (dataWord !== 12'h000 || dataValid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: dataWord=%h dataValid=%b, want 000/0", dataWord, dataValid);
        end
        req(11'd1, 5'd0, e);
        n_vec++;
        if (dataWord !== IDLE || dataValid !== 1'b1) begin
            n_err++;
            $display("FAIL after_reset_idle: dataWord=%h dataValid=%b, want 002/1", dataWord, dataValid);
        end
    endtask

    task automatic test_random();
        logic [11:0] e;
        logic [9:0]  init;
        logic [10:0] mask;
        int unsigned r;
        for (int c = 0; c < NUM_CH; c++) begin
            r    = $urandom_range(0, 2);
            init = (r == 0) ? 10'h000 : (r == 1) ? 10'h3FF : 10'($urandom);
            mask = ($urandom_range(0, 3) == 0) ? 11'h000 : 11'($urandom_range(0, 31));
            cfg(3'(c), 3'($urandom_range(0, 5)), 11'($urandom_range(0, 31)), mask, init,
                5'($urandom_range(0, 3)));
        end
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 7);
            if (r == 0) begin
                idle(e);
                n_vec++;
                if (dataWord !== e || dataValid !== 1'b0) begin
                    n_err++;
                    $display("FAIL rand_hold[%0d]: dataWord=%h dataValid=%b, want %h/0", n, dataWord, dataValid, e);
                end
            end else begin
                if (r == 1) begin
                    init = ($urandom_range(0, 1) == 0) ? 10'h3FF : 10'($urandom);
                    drive_cycle(1'b1, 11'($urandom_range(0, 31)), 5'($urandom_range(0, 3)), 1'b1,
                                3'($urandom_range(0, 7)), 3'($urandom_range(0, 5)),
                                11'($urandom_range(0, 31)), 11'($urandom_range(0, 31)), init,
                                5'($urandom_range(0, 3)), e);
                end else begin
                    req(11'($urandom_range(0, 31)), 5'($urandom_range(0, 3)), e);
                end
                n_vec++;
                if (dataWord !== e || dataValid !== 1'b1) begin
                    n_err++;
                    $display("FAIL rand_req[%0d]: dataWord=%h dataValid=%b, want %h/1", n, dataWord, dataValid, e);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b0; bufGetWord = 1'b0; bufRdPointer = '0; numGrp = '0;
        cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0; cfg_slot = '0;
        cfg_mask = '0; cfg_init = '0; cfg_grp = '0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_up();
        test_down();
        test_const_priority();
        test_grp_up();
        test_updown_and_cfg_collision();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, n_err=%0d", n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
